// File: rtl/ws2812_pkg.sv
// Shared types, default 12 MHz timing and the brightness scaler for the WS2812 chain driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BITS  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // 12 MHz clock: 1.25 us bit, ~0.83 us / ~0.42 us high times, 50 us latch.
    localparam int DEF_T_PERIOD = 15;
    localparam int DEF_T1H      = 10;
    localparam int DEF_T0H      = 5;
    localparam int DEF_T_RESET  = 600;

    // (c * (b + 1)) >> 8: b = 255 is the identity, b = 0 always yields 0.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_fb_ram.sv
// Per-LED frame buffer: simple dual-port RAM, registered read, read-before-write, no reset.
module ws2812_fb_ram
    import ws2812_pkg::*;
#(
    parameter int LEDS  = 8,
    parameter int WIDTH = 24,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Full address-space depth keeps indexing width-exact; entries >= LEDS are never written.
    logic [WIDTH-1:0] mem [2**AW];
    logic             wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < LEDS);

    // Write and registered read; a same-address read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// WS2812/SK6812 chain driver: frame buffer, gap-free bit streaming, latch period, brightness scaling.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int LEDS          = 8,
    parameter int BYTES_PER_LED = 3,
    parameter int T_PERIOD      = DEF_T_PERIOD,
    parameter int T1H           = DEF_T1H,
    parameter int T0H           = DEF_T0H,
    parameter int T_RESET       = DEF_T_RESET,
    parameter int AW            = (LEDS > 1) ? $clog2(LEDS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [8*BYTES_PER_LED-1:0] wr_data,
    input  logic [7:0]                 brightness,
    input  logic                       start,
    input  logic                       auto_refresh,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       data
);

    localparam int W  = 8 * BYTES_PER_LED;
    localparam int CW = $clog2(T_PERIOD);
    localparam int BW = $clog2(W);
    localparam int RW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [BW-1:0]   bit_reg, bit_next;
    logic [AW-1:0]   led_reg, led_next;
    logic [RW-1:0]   latch_cnt_reg, latch_cnt_next;
    logic [7:0]      bright_reg, bright_next;
    logic [W-1:0]    word_reg, word_next;
    logic [W-1:0]    stage_reg, stage_next;
    logic            first_reg, first_next;
    logic            data_reg, data_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [W-1:0]    rd_data;
    logic [W-1:0]    scaled_rd;
    logic [W-1:0]    cur_word;
    logic            cur_bit;
    logic            last_bit;
    logic            last_led;

    ws2812_fb_ram #(
        .LEDS  (LEDS),
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Per-byte brightness scaling of the RAM read port, using the brightness latched for this frame.
    for (genvar gi = 0; gi < BYTES_PER_LED; gi++) begin : g_scale
        assign scaled_rd[gi*8 +: 8] = scale_byte(rd_data[gi*8 +: 8], bright_reg);
    end

    // LED 0 has no prefetch slot, so its first bit cycle reads the scaled RAM output directly.
    assign cur_word = first_reg ? scaled_rd : word_reg;
    assign cur_bit  = cur_word[W-1];
    assign last_bit = (bit_reg == BW'(W - 1));
    assign last_led = (led_reg == AW'(LEDS - 1));

    // Next-state, counter, datapath and output decode.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_next       = bit_reg;
        led_next       = led_reg;
        latch_cnt_next = latch_cnt_reg;
        bright_next    = bright_reg;
        word_next      = word_reg;
        stage_next     = stage_reg;
        first_next     = 1'b0;
        data_next      = 1'b0;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start || auto_refresh) begin
                    state_next  = ST_LOAD;
                    busy_next   = 1'b1;
                    bright_next = brightness;
                    cnt_next    = '0;
                    bit_next    = '0;
                    led_next    = '0;
                end
            end
            ST_LOAD: begin
                rd_en      = 1'b1;
                rd_addr    = '0;
                first_next = 1'b1;
                state_next = ST_BITS;
            end
            ST_BITS: begin
                data_next = (cnt_reg < (cur_bit ? CW'(T1H) : CW'(T0H)));
                if (first_reg) begin
                    word_next = scaled_rd;
                end
                // Prefetch the next LED during the last bit: read on cnt 0, stage on cnt 1.
                if (last_bit && !last_led && (cnt_reg == '0)) begin
                    rd_en   = 1'b1;
                    rd_addr = led_reg + AW'(1);
                end
                if (last_bit && !last_led && (cnt_reg == CW'(1))) begin
                    stage_next = scaled_rd;
                end
                if (cnt_reg == CW'(T_PERIOD - 1)) begin
                    cnt_next = '0;
                    if (last_bit) begin
                        bit_next = '0;
                        if (last_led) begin
                            led_next       = '0;
                            latch_cnt_next = '0;
                            state_next     = ST_LATCH;
                        end else begin
                            led_next  = led_reg + AW'(1);
                            word_next = stage_reg;
                        end
                    end else begin
                        bit_next  = bit_reg + BW'(1);
                        word_next = cur_word << 1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_LATCH: begin
                if (latch_cnt_reg == RW'(T_RESET - 1)) begin
                    latch_cnt_next = '0;
                    state_next     = ST_IDLE;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                end else begin
                    latch_cnt_next = latch_cnt_reg + RW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, word pipeline and registered outputs; reset drops the line low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            bit_reg       <= '0;
            led_reg       <= '0;
            latch_cnt_reg <= '0;
            bright_reg    <= '0;
            word_reg      <= '0;
            stage_reg     <= '0;
            first_reg     <= 1'b0;
            data_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            led_reg       <= led_next;
            latch_cnt_reg <= latch_cnt_next;
            bright_reg    <= bright_next;
            word_reg      <= word_next;
            stage_reg     <= stage_next;
            first_reg     <= first_next;
            data_reg      <= data_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign data       = data_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: a 2-LED GRB chain and an 8-LED GRBW chain against a waveform model.
module tb_ws2812_chain_driver;

    localparam int TP = 15;
    localparam int T1 = 10;
    localparam int T0 = 5;
    localparam int TR = 600;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to time frame_done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, auto_a, wr_en_a, busy_a, done_a, data_a;
    logic [1:0]  wr_addr_a;
    logic [23:0] wr_data_a;
    logic [7:0]  bright_a;

    logic        start_b, auto_b, wr_en_b, busy_b, done_b, data_b;
    logic [2:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [7:0]  bright_b;

    int          n_vec = 0;
    int          n_bad = 0;
    int          last_done_cyc = 0;
    logic [31:0] mem_m [2][8];

    ws2812_chain_driver #(
        .LEDS(2), .BYTES_PER_LED(3), .T_PERIOD(TP), .T1H(T1), .T0H(T0), .T_RESET(TR), .AW(2)
    ) dut_a (
        .clk(clk), .reset(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .brightness(bright_a), .start(start_a), .auto_refresh(auto_a),
        .busy(busy_a), .frame_done(done_a), .data(data_a)
    );

    ws2812_chain_driver #(
        .LEDS(8), .BYTES_PER_LED(4), .T_PERIOD(TP), .T1H(T1), .T0H(T0), .T_RESET(TR), .AW(3)
    ) dut_b (
        .clk(clk), .reset(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .brightness(bright_b), .start(start_b), .auto_refresh(auto_b),
        .busy(busy_b), .frame_done(done_b), .data(data_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_led(input int sel);
        return (sel != 0) ? 8 : 2;
    endfunction

    function automatic int n_bpl(input int sel);
        return (sel != 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] fit(input int sel, input logic [31:0] w);
        return (sel != 0) ? w : {8'h00, w[23:0]};
    endfunction

    task automatic set_in(input int sel, input logic st, input logic we, input int addr, input logic [31:0] wd);
        if (sel == 0) begin
            start_a = st; wr_en_a = we; wr_addr_a = addr[1:0]; wr_data_a = wd[23:0];
        end else begin
            start_b = st; wr_en_b = we; wr_addr_b = addr[2:0]; wr_data_b = wd;
        end
    endtask

    // Idle-time host write, called on a falling edge; returns one cycle later.
    task automatic host_write(input int sel, input int addr, input logic [31:0] word);
        set_in(sel, 1'b0, 1'b1, addr, word);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 0, 32'h0);
        if (addr < n_led(sel)) mem_m[sel][addr] = fit(sel, word);
    endtask

    // One frame checked cycle by cycle. Sample k is the cycle after the edge that saw the trigger.
    // Optional write at sample wr_k and extra start pulse at sample st_k (-1 = none).
    task automatic run_frame(input string name, input int sel, input bit trig,
                             input int wr_k, input int wr_led, input logic [31:0] wr_word,
                             input int st_k, input int tail, output logic [31:0] word0);
        int   leds, bpl, nbits, bsy, bright;
        int   wave_bad, first_bad, busy_cnt, done_cnt, rise_k;
        logic [31:0] w;
        bit   bits[$];
        logic d, b, f, ed, eb, ef;

        leds   = n_led(sel);
        bpl    = n_bpl(sel);
        nbits  = leds * bpl * 8;
        bsy    = 1 + nbits * TP + TR;
        bright = (sel != 0) ? int'(bright_b) : int'(bright_a);

        // Expected bit stream: each LED's word as stored when its read happens, bytes scaled.
        for (int l = 0; l < leds; l++) begin
            int rk;
            rk = (l == 0) ? 0 : 1 + (l * bpl * 8 - 1) * TP;
            w  = mem_m[sel][l];
            if (wr_k >= 0 && wr_led == l && wr_k < rk) w = fit(sel, wr_word);
            for (int y = bpl - 1; y >= 0; y--) begin
                int c, s;
                c = int'((w >> (8 * y)) & 32'hFF);
                s = (c * (bright + 1)) / 256;
                for (int k = 7; k >= 0; k--) bits.push_back(((s >> k) & 1) == 1);
            end
        end

        if (trig) set_in(sel, 1'b1, 1'b0, 0, 32'h0);
        wave_bad = 0; first_bad = -1; busy_cnt = 0; done_cnt = 0; rise_k = -1; word0 = '0;

        for (int k = 0; k <= bsy + tail; k++) begin
            @(negedge clk);
            d = (sel != 0) ? data_b : data_a;
            b = (sel != 0) ? busy_b : busy_a;
            f = (sel != 0) ? done_b : done_a;
            ed = 1'b0;
            if (k >= 2 && k < 2 + nbits * TP) begin
                int j;
                j  = k - 2;
                ed = ((j % TP) < (bits[j / TP] ? T1 : T0));
            end
            eb = (k < bsy);
            ef = (k == bsy);
            if ({d, b, f} !== {ed, eb, ef}) begin
                wave_bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (b === 1'b1) busy_cnt++;
            if (f === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (rise_k < 0 && d === 1'b1) rise_k = k;
            if (k >= 2 && ((k - 2) % TP) == T0 && ((k - 2) / TP) < bpl * 8) word0 = {word0[30:0], d};
            set_in(sel, (k == st_k), (k == wr_k), wr_led, wr_word);
        end

        if (wr_k >= 0 && wr_led < leds) mem_m[sel][wr_led] = fit(sel, wr_word);

        chk({name, "_wave_bad_cycles"}, 64'(wave_bad), 64'd0);
        if (wave_bad != 0) $display("  %s first differing cycle %0d", name, first_bad);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(bsy));
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_first_rise"}, 64'(rise_k), 64'd2);
    endtask

    initial begin
        logic [31:0] w0;
        int d1, d2, rk1;

        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 0, 32'h0);
        set_in(1, 1'b0, 1'b0, 0, 32'h0);
        auto_a = 1'b0; auto_b = 1'b0;
        bright_a = 8'd255; bright_b = 8'd255;
        repeat (3) @(negedge clk);
        chk("reset_a_data", 64'(data_a), 64'd0);
        chk("reset_a_busy", 64'(busy_a), 64'd0);
        chk("reset_a_done", 64'(done_a), 64'd0);
        chk("reset_b_data", 64'(data_b), 64'd0);
        chk("reset_b_busy", 64'(busy_b), 64'd0);
        chk("reset_b_done", 64'(done_b), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 2-LED frame at full brightness.
        host_write(0, 0, 32'hFF0000);
        host_write(0, 1, 32'h000001);
        run_frame("basic", 0, 1'b1, -1, 0, 32'h0, -1, 3, w0);
        chk("basic_led0_word", 64'(w0), 64'hFF0000);

        // Brightness 127 scaling of a known word.
        host_write(0, 0, 32'h80FF40);
        bright_a = 8'd127;
        run_frame("bright127", 0, 1'b1, -1, 0, 32'h0, -1, 3, w0);
        chk("bright127_led0_word", 64'(w0), 64'h407F20);

        // start pulsed while busy must not queue a second frame.
        bright_a = 8'd255;
        run_frame("start_busy", 0, 1'b1, -1, 0, 32'h0, 500, 8, w0);

        // LED1 written before and exactly on its prefetch read cycle.
        rk1 = 1 + (24 - 1) * TP;
        run_frame("wr_before", 0, 1'b1, 100, 1, 32'h00A5C3, -1, 3, w0);
        run_frame("wr_on_read", 0, 1'b1, rk1, 1, 32'h3C5A00, -1, 3, w0);

        // Randomized contents, brightness and mid-frame writes.
        for (int r = 0; r < 3; r++) begin
            host_write(0, 0, $urandom);
            host_write(0, 1, $urandom);
            bright_a = 8'($urandom_range(0, 255));
            run_frame("random", 0, 1'b1, $urandom_range(0, 800), $urandom_range(0, 1), $urandom, -1, 3, w0);
        end

        // Out-of-range addresses leave the buffer untouched.
        host_write(0, 2, $urandom);
        host_write(0, 3, $urandom);
        run_frame("addr_ignore", 0, 1'b1, -1, 0, 32'h0, -1, 3, w0);

        // Reset mid-frame while the line is high, then resend the unchanged buffer.
        set_in(0, 1'b1, 1'b0, 0, 32'h0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 0, 32'h0);
        repeat (107) @(negedge clk);
        chk("midframe_data_high", 64'(data_a), 64'd1);
        chk("midframe_busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_data", 64'(data_a), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_reset", 0, 1'b1, -1, 0, 32'h0, -1, 3, w0);

        // GRBW chain in auto-refresh: two back-to-back frames.
        for (int l = 0; l < 8; l++) host_write(1, l, $urandom);
        bright_b = 8'($urandom_range(0, 255));
        auto_b = 1'b1;
        run_frame("auto1", 1, 1'b0, -1, 0, 32'h0, -1, 0, w0);
        d1 = last_done_cyc;
        run_frame("auto2", 1, 1'b0, -1, 0, 32'h0, -1, 0, w0);
        d2 = last_done_cyc;
        auto_b = 1'b0;
        chk("auto_done_period", 64'(d2 - d1), 64'(1 + 8 * 32 * TP + TR + 1));
        repeat (5) @(negedge clk);
        chk("auto_off_idle_busy", 64'(busy_b), 64'd0);
        chk("auto_off_idle_data", 64'(data_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
